lut_rom_pipe: RTL

//  Parametrised, clocked lookup table: the registered successor of the 5-bit combinational ROM.

---
 rtl/lut_rom_pkg.sv | 16 +
 rtl/lut_rom_skid.sv | 33 +++
 rtl/lut_rom_pipe.sv | 54 +++++
 3 files changed

// File: rtl/lut_rom_pkg.sv
// lut_rom_pkg: reset-pattern encodings and preset helper for lut_rom_pipe
package lut_rom_pkg;
  localparam int LUT_INIT_IDENT  = 0;
  localparam int LUT_INIT_BITREV = 1;
  localparam int LUT_INIT_ZERO   = 2;
  function automatic logic [31:0] lut_init_val(input int mode, input int addr, input int aw, input int dw);
    logic [31:0] a, v;
    a = addr;
    v = '0;
    for (int i = 0; i < 32; i++)
      if (i < aw) v[i] = (mode == LUT_INIT_BITREV) ? a[aw-1-i] : (mode == LUT_INIT_IDENT) ? a[i] : 1'b0;
    for (int i = 0; i < 32; i++)
      if (i >= dw) v[i] = 1'b0;
    return v;
  endfunction
endpackage

// File: rtl/lut_rom_skid.sv
// lut_rom_skid: one-entry skid buffer in front of a registered output stage
module lut_rom_skid #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic [W-1:0] skid_data;
  logic         skid_full;
  assign in_ready = !skid_full;
  // output loads from skid first (ordering), else from input; stalled accepts park in skid
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_full <= 1'b0;
      skid_data <= '0;
    end else if (!out_valid || out_ready) begin
      out_valid <= skid_full || in_valid;
      if (skid_full) out_data <= skid_data;
      else if (in_valid) out_data <= in_data;
      skid_full <= 1'b0;
    end else if (in_valid && !skid_full) begin
      skid_full <= 1'b1;
      skid_data <= in_data;
    end
endmodule

// File: rtl/lut_rom_pipe.sv
// lut_rom_pipe: registered, rewritable lookup table with valid/ready and skid buffering
module lut_rom_pipe
  import lut_rom_pkg::*;
#(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 5,
  parameter int DEPTH     = 1 << ADDR_W,
  parameter int INIT_MODE = LUT_INIT_IDENT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);
  logic [DATA_W-1:0] tbl [DEPTH];
  logic              rd_ok, wr_ok;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W:0]   pay, res;
  if (DEPTH < (1 << ADDR_W)) begin : g_part
    assign rd_ok = in_addr < ADDR_W'(DEPTH);
    assign wr_ok = wr_addr < ADDR_W'(DEPTH);
  end else begin : g_full
    assign rd_ok = 1'b1;
    assign wr_ok = 1'b1;
  end
  assign rd_val = (wr_en && wr_ok && wr_addr == in_addr) ? wr_data : tbl[in_addr];
  assign pay    = rd_ok ? {1'b0, rd_val} : {1'b1, {DATA_W{1'b0}}};
  // table preset from the selected pattern on reset, rewritten by in-range writes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= DATA_W'(lut_init_val(INIT_MODE, i, ADDR_W, DATA_W));
    end else if (wr_en && wr_ok) begin
      tbl[wr_addr] <= wr_data;
    end
  lut_rom_skid #(.W(DATA_W + 1)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pay),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (res)
  );
  assign {out_err, out_data} = res;
endmodule
